safecrack_input_conditioner: RTL and testbench

SAFECRACK_INPUT_CONDITIONER -- requirements
Module: safecrack_input_conditioner

---
 rtl/safecrack_input_conditioner.sv | 124 ++++++++++++
 tb/tb_safecrack_input_conditioner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/safecrack_input_conditioner.sv
// Button front end for the safecrack lock: synchronize, debounce, one strobe per press.
// Optional seconds timebase compiled in with `define SAFECRACK_SEC_TICK_EN.
module safecrack_input_conditioner #(
  parameter int DB_CYCLES   = 500000,
  parameter int TICK_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       tick_clr,
  output logic [3:0] btn,
  output logic       btn_valid,
  output logic       sec_tick,
  output logic [1:0] dbg_state
);

  localparam int             DBW     = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [3:0]     r_db;
  logic [DBW-1:0] r_db_cnt [4];
  logic [3:0]     r_btn;
  state_t         r_state;
  state_t         w_next;
  logic           w_btn_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A level flips only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db <= 4'hF;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_btn   <= 4'hF;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && r_db != 4'hF) r_btn <= r_db;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_btn_valid = 1'b0;
    case (r_state)
      ST_IDLE:  if (r_db != 4'hF) w_next = ST_PRESS;
      ST_PRESS: begin
        w_btn_valid = 1'b1;
        w_next      = ST_HOLD;
      end
      ST_HOLD:  if (r_db == 4'hF) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign btn       = r_btn;
  assign btn_valid = w_btn_valid;
  assign dbg_state = r_state;

`ifdef SAFECRACK_SEC_TICK_EN
  localparam int            TW        = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0] r_tick_cnt;
  logic          r_sec_tick;

  // Clear has priority so a restart never emits a tick in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_sec_tick <= 1'b0;
    end else if (tick_clr) begin
      r_tick_cnt <= '0;
      r_sec_tick <= 1'b0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
      r_sec_tick <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
      r_sec_tick <= 1'b0;
    end
  end

  assign sec_tick = r_sec_tick;
`else
  // Timebase absent: tick_clr and TICK_CYCLES are intentionally unused.
  logic w_unused_tick;
  assign w_unused_tick = tick_clr & (TICK_CYCLES > 1);
  assign sec_tick      = 1'b0;
`endif

endmodule

// File: tb/tb_safecrack_input_conditioner.sv
// Bench for safecrack_input_conditioner with DB_CYCLES=4, TICK_CYCLES=8.
// Expected strobes (pattern and cycle) are queued at stimulus time and checked by a monitor.
module tb_safecrack_input_conditioner;

  localparam int DB   = 4;
  localparam int TICK = 8;
  localparam int LAT  = 2 + DB + 1;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic       tick_clr;
  logic [3:0] btn;
  logic       btn_valid;
  logic       sec_tick;
  logic [1:0] dbg_state;

  int         cyc;
  int         pass_cnt;
  int         total_cnt;
  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];

  safecrack_input_conditioner #(
    .DB_CYCLES  (DB),
    .TICK_CYCLES(TICK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .tick_clr (tick_clr),
    .btn      (btn),
    .btn_valid(btn_valid),
    .sec_tick (sec_tick),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (btn_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_strobe: btn=%b at cyc %0d, no strobe expected", btn, cyc);
      end else begin
        logic [3:0] e;
        int         ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        total_cnt++;
        if (btn !== e) $display("FAIL strobe_btn: got %b expected %b", btn, e);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== ec) $display("FAIL strobe_cycle: got %0d expected %0d", cyc, ec);
        else pass_cnt++;
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_press(input logic [3:0] pat);
    btn_raw = pat;
    exp_q.push_back(pat);
    exp_cyc_q.push_back(cyc + LAT);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_raw = 4'hF; tick_clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (btn !== 4'hF) $display("FAIL reset_btn: got %b expected 1111", btn); else pass_cnt++;
    total_cnt++; if (btn_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", btn_valid); else pass_cnt++;
    total_cnt++; if (sec_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", sec_tick); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else pass_cnt++;
    btn_raw = 4'h0;
    wait_cycles(3);
    total_cnt++; if (btn !== 4'hF) $display("FAIL reset_btn_clocked: got %b expected 1111", btn); else pass_cnt++;
    btn_raw = 4'hF;
    rst = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_clean_press();
    drive_press(4'b1110);
    wait_cycles(20);
    btn_raw = 4'hF;
    wait_cycles(12);
    total_cnt++; if (btn !== 4'b1110) $display("FAIL clean_btn_held: got %b expected 1110", btn); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL clean_idle: got %0d expected 0", dbg_state); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL clean_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_bounce();
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      btn_raw = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      wait_cycles(2);
    end
    btn_raw = 4'hF;
    wait_cycles(12);
    total_cnt++; if (btn !== 4'hF) $display("FAIL bounce_btn: got %b expected 1111", btn); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL bounce_idle: got %0d expected 0", dbg_state); else pass_cnt++;
  endtask

  task automatic test_db_boundary();
    btn_raw = 4'b1011;
    wait_cycles(DB - 1);
    btn_raw = 4'hF;
    wait_cycles(12);
    total_cnt++; if (btn !== 4'hF) $display("FAIL short_pulse_btn: got %b expected 1111", btn); else pass_cnt++;
    drive_press(4'b1011);
    wait_cycles(DB);
    btn_raw = 4'hF;
    wait_cycles(14);
    total_cnt++; if (exp_q.size() != 0) $display("FAIL exact_pulse_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL exact_pulse_idle: got %0d expected 0", dbg_state); else pass_cnt++;
  endtask

  task automatic test_hold_second_key();
    drive_press(4'b0111);
    wait_cycles(25);
    btn_raw = 4'b0110;
    wait_cycles(25);
    total_cnt++; if (btn !== 4'b0111) $display("FAIL hold_btn: got %b expected 0111", btn); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd2) $display("FAIL hold_state: got %0d expected 2", dbg_state); else pass_cnt++;
    btn_raw = 4'hF;
    wait_cycles(10);
    drive_press(4'b1101);
    wait_cycles(20);
    btn_raw = 4'hF;
    wait_cycles(12);
    total_cnt++; if (btn !== 4'b1101) $display("FAIL second_btn: got %b expected 1101", btn); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL second_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_timebase();
    for (int run = 0; run < 2; run++) begin
      pulse_reset();
      for (int n = 1; n <= 40; n++) begin
        logic exp_tick;
        @(posedge clk);
        #1;
        if (run == 1 && n == 13) tick_clr = 1'b1;
        if (n == 14) tick_clr = 1'b0;
`ifdef SAFECRACK_SEC_TICK_EN
        if (run == 0) exp_tick = (n % TICK == 0);
        else          exp_tick = (n == 8) || (n >= 22 && (n - 22) % TICK == 0);
`else
        exp_tick = 1'b0;
`endif
        @(negedge clk);
        total_cnt++;
        if (sec_tick !== exp_tick)
          $display("FAIL tick_run%0d_cycle%0d: got %b expected %b", run, n, sec_tick, exp_tick);
        else pass_cnt++;
      end
      tick_clr = 1'b0;
    end
  endtask

  task automatic test_reset_mid_press();
    pulse_reset();
    drive_press(4'b1110);
    wait_cycles(12);
    total_cnt++; if (dbg_state !== 2'd2) $display("FAIL mid_hold_state: got %0d expected 2", dbg_state); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (btn !== 4'hF) $display("FAIL mid_reset_btn: got %b expected 1111", btn); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL mid_reset_state: got %0d expected 0", dbg_state); else pass_cnt++;
    total_cnt++; if (btn_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b expected 0", btn_valid); else pass_cnt++;
    wait_cycles(3);
    rst = 1'b1;
    exp_q.push_back(4'b1110);
    exp_cyc_q.push_back(cyc + LAT);
    wait_cycles(20);
    btn_raw = 4'hF;
    wait_cycles(12);
    total_cnt++; if (btn !== 4'b1110) $display("FAIL mid_repress_btn: got %b expected 1110", btn); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL mid_repress_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
  endtask

  // test sequence and final report
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_db_boundary();
    test_hold_second_key();
    test_timebase();
    test_reset_mid_press();
    wait_cycles(4);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
